// File: rtl/mem_access_master_if.sv
// Request/response handshake plus word-addressed memory port of the MEM-stage access master.
// The master modport is the access master's view; slave is the pipeline/memory side.
interface mem_access_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_A, mem_WD, mem_WE
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/mem_access_master.sv
// MEM-stage load/store master: byte-addressed requests onto a word-addressed memory,
// sub-word stores via read-modify-write, sign/zero-extended sub-word loads.
module mem_access_master #(
    parameter int DEPTH = 100,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_master_if.master bus,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LD     = 3'd1;
    localparam logic [2:0] ST     = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]  state;
    logic        we_q;
    logic        sgn_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        req_err;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) r[{off, 3'b000} +: 8] = d[7:0];
        else             r[{off[1], 4'b0000} +: 16] = d[15:0];
        return r;
    endfunction

    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        sgn_q   <= bus.req_signed;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        err_q   <= req_err;
                        rdata_q <= '0;
                        if (req_err)                    state <= RESP;
                        else if (!bus.req_we)           state <= LD;
                        else if (bus.req_size == 2'b10) state <= ST;
                        else                            state <= RMW_RD;
                    end
                end
                LD: begin
                    rdata_q <= load_extract(bus.mem_RD, size_q, addr_q[1:0], sgn_q);
                    state   <= RESP;
                end
                ST:     state <= RESP;
                RMW_RD: begin
                    merge_q <= bus.mem_RD;
                    state   <= RMW_WR;
                end
                RMW_WR: state <= RESP;
                RESP: begin
                    // Counters only see error-free completions and stick at all-ones.
                    if (!err_q) begin
                        if (we_q) begin
                            if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
                        end else begin
                            if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
                        end
                    end
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side is decoded purely from registered state, so req_* never reaches mem_*.
    always_comb begin
        bus.mem_A  = '0;
        bus.mem_WD = '0;
        bus.mem_WE = 1'b0;
        case (state)
            LD, RMW_RD: bus.mem_A = {2'b00, addr_q[31:2]};
            ST: begin
                bus.mem_A  = {2'b00, addr_q[31:2]};
                bus.mem_WD = wdata_q;
                bus.mem_WE = 1'b1;
            end
            RMW_WR: begin
                bus.mem_A  = {2'b00, addr_q[31:2]};
                bus.mem_WD = lane_merge(merge_q, wdata_q, size_q, addr_q[1:0]);
                bus.mem_WE = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_access_master.sv
// Random and directed load/store traffic against a byte-array reference memory, with a
// scoreboard monitor checking response data, error flag, latency and write-pulse count.
module tb_mem_access_master;
    localparam int DEPTH = 100;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [CNT_W-1:0] load_cnt, store_cnt;

    mem_access_master_if bus();

    mem_access_master #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        int          wes;
    } exp_t;

    logic [31:0] mem [DEPTH];
    logic [7:0]  rb  [4*DEPTH];
    exp_t sbq[$];
    int cmps = 0, errs = 0, cyc = 0, we_seen = 0, ld_exp = 0, st_exp = 0;

    always_comb begin
        bus.mem_RD = 32'h0;
        if (bus.mem_A < 32'(DEPTH)) bus.mem_RD = mem[int'(bus.mem_A)];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_WE && bus.mem_A < 32'(DEPTH)) mem[int'(bus.mem_A)] <= bus.mem_WD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    // Reference behaviour on a flat little-endian byte array.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int nb;
        logic [31:0] v;
        e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || (a[31:2] >= DEPTH);
        e.rdata = 32'h0;
        e.wes   = 0;
        e.cyc   = 1;
        if (!e.err) begin
            nb = 1 << sz;
            if (we) begin
                for (int i = 0; i < nb; i++) rb[int'(a) + i] = wd[8*i +: 8];
                e.wes = 1;
                e.cyc = (nb == 4) ? 2 : 3;
                st_exp++;
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = rb[int'(a) + i];
                if (sg && nb < 4 && v[8*nb-1])
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
                e.cyc   = 2;
                ld_exp++;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit track);
        int n, guard;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            cmps++; errs++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (t=%0t)", $time);
            bus.req_valid = 1'b0;
            return;
        end
        n = cyc;
        @(posedge clk);
        if (track) begin
            model(we, sz, sg, a, wd, e);
            e.cyc = n + e.cyc;
            sbq.push_back(e);
        end
        #1;
        // Scramble the request fields while busy; the latched copy must be used.
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
        bus.req_signed = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            cmps++; errs++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            we_seen = 0;
        end else begin
            if (bus.mem_WE) begin
                we_seen++;
                chk("we_addr_in_range", 32'(bus.mem_A < 32'(DEPTH)), 32'd1);
            end
            if (bus.rsp_valid) begin
                if (sbq.size() == 0) begin
                    cmps++; errs++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk("we_pulses", 32'(we_seen), 32'(e.wes));
                end
                we_seen = 0;
            end
        end
    end

    initial begin
        logic [31:0] a, w;
        logic [1:0]  sz;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) rb[4*i + b] = w[8*b +: 8];
        end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = 32'h8; bus.req_wdata = 32'h12345678;

        // Reset held for two edges with a pending request.
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_mem_WE", 32'(bus.mem_WE), 32'd0);
            chk("rst_mem_A", bus.mem_A, 32'd0);
            chk("rst_mem_WD", bus.mem_WD, 32'd0);
            chk("rst_cnts", {load_cnt, store_cnt}, 32'd0);
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        chk("rst_mem_word2", mem[2], ref_word(2));

        // Word store then load back.
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 1'b1);
        drain();
        chk("word_store_mem", mem[2], 32'hDEADBEEF);
        chk("store_cnt_1", 32'(store_cnt), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1);

        // Sub-word load extraction.
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h80FF7F01, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'hB, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, 1'b1);

        // Byte read-modify-write.
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFFFFAB, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h1E, 32'h0000C0DE, 1'b1);
        drain();
        chk("rmw_byte_mem", mem[2], 32'h1122AB44);
        chk("rmw_half_mem", mem[7], ref_word(7));

        // Error cases.
        issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h6, 32'h55555555, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h66666666, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'h77777777, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'(4*DEPTH - 1), 32'h0, 1'b1);

        // Random traffic.
        for (int k = 0; k < 200; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
            if (sz == 2'd1 && $urandom_range(0, 1) == 1) a[0] = 1'b0;
            if (sz == 2'd2 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
        end
        drain();
        chk("load_cnt_total", 32'(load_cnt), 32'(ld_exp));
        chk("store_cnt_total", 32'(store_cnt), 32'(st_exp));
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_word(i)) chk("mem_final", mem[i], ref_word(i));
        chk("mem_word2_final", mem[2], ref_word(2));

        // Reset during the read half of a read-modify-write.
        issue(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000CD, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_mem_WE", 32'(bus.mem_WE), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_cnts", {load_cnt, store_cnt}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_word2", mem[2], ref_word(2));
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator side of the word-addressed data-memory port (word index A, write data WD, write enable WE, combinational read RD, write on clk rising edge).
- Sits in the MEM stage. It accepts byte-addressed load/store requests from the pipeline and drives the memory port.
- Sub-word stores are done as read-modify-write. Loads are extracted and sign- or zero-extended.
- Holds req_ready low while busy so the pipeline stalls.

Parameters:
- DEPTH, 100, number of 32-bit words in the attached memory. Word index >= DEPTH is out of range.
- CNT_W, 16, width of the saturating access counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready at a rising edge
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  error flag, valid with rsp_valid
- rsp_rdata  out  32  load result, valid with rsp_valid
- mem_A  out  32  word index {2'b00, addr[31:2]}
- mem_WD  out  32  write data
- mem_WE  out  1  write enable
- mem_RD  in  32  combinational read data for mem_A
- load_cnt  out  CNT_W  completed error-free loads, saturating
- store_cnt  out  CNT_W  completed error-free stores, saturating

Behaviour:
- Reset: rst low at a rising edge forces the following, regardless of state, and drops any in-flight request (a half-done RMW never issues its write):
  - state=IDLE
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
  - mem_WE=0, mem_A=0, mem_WD=0
  - counters=0
- States: IDLE, LD, ST, RMW_RD, RMW_WR, RESP.
- Memory-side outputs are decoded from registered state and latched request only. No combinational path from req_* to mem_*.
- req_ready=1 only in IDLE. Latched fields: we, size, signed, addr, wdata.
- IDLE, on accept:
  - Error cases go to RESP with err=1 and no memory write:
    - size=11
    - halfword with addr[0]=1
    - word with addr[1:0]!=0
    - addr[31:2] >= DEPTH
  - Otherwise the next state is:
    - load -> LD
    - word store -> ST
    - byte or halfword store -> RMW_RD
- LD: mem_A=index, mem_WE=0. At the edge, capture the extracted lane of mem_RD into rsp_rdata, then -> RESP.
  - Byte lane = addr[1:0]; halfword lane = addr[1]. Little-endian (byte 0 = bits 7:0).
  - Extension: sign if req_signed, else zero. Word loads ignore req_signed.
- ST: mem_A=index, mem_WD=wdata, mem_WE=1 for exactly this cycle, then -> RESP.
- RMW_RD: mem_A=index, mem_WE=0. Capture mem_RD into the merge register, then -> RMW_WR.
- RMW_WR: mem_A=index, mem_WE=1, then -> RESP.
  - mem_WD = merge register with the selected lane replaced by wdata[7:0] or wdata[15:0]. Other bytes are unchanged.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. rsp_rdata=0 for stores and errors.
- Counters: increment on leaving RESP with err=0. Hold at all-ones.
- Latency, accept edge to the cycle rsp_valid is high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP. Throughput is at best one load per 3 cycles.
- mem_WE is never high outside ST or RMW_WR.
- req_* changing while not in IDLE has no effect.

Test Plan:
- Reset: hold rst=0 for 2 edges with req_valid=1 -> req_ready=1, all outputs 0, no mem_WE pulse.
- Word store then load:
  - Store addr=0x8, wdata=0xDEADBEEF -> mem_A=2, mem_WE pulse of 1 cycle, rsp_valid at cycle 2, store_cnt=1.
  - Load addr=0x8 -> rsp_rdata=0xDEADBEEF.
- Sub-word loads with word 2 = 0x80FF7F01:
  - byte addr=0xB, signed -> 0xFFFFFF80
  - byte addr=0xB, unsigned -> 0x00000080
  - half addr=0xA, signed -> 0xFFFF80FF
- Byte RMW: word 2 = 0x11223344, byte store addr=0x9, wdata=0xAB -> the single WE cycle carries mem_WD=0x1122AB44; rsp_valid 3 cycles after accept.
- Errors, each -> rsp_err=1 one cycle after accept, no mem_WE, counters unchanged:
  - half addr=0x3
  - word addr=0x6
  - size=11
  - word addr=4*DEPTH
- Reset mid-RMW: assert rst=0 in the RMW_RD cycle -> no write issued, word 2 unchanged, state IDLE, rsp_valid never asserted.
